// File: rtl/pipeline_drain_buffer.sv
// Drain buffer behind the global-stall address pipeline: captures requests leaving the
// last stage into a small FIFO, presents them over valid/ready, stalls the pipeline when
// full and checks that request IDs arrive in sequence.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module pipeline_drain_buffer #(
    parameter int unsigned ADDRESS_WIDTH = `ADDRESS_WIDTH,
    parameter int unsigned ID_WIDTH      = `ID_WIDTH,
    parameter int unsigned FIFO_DEPTH    = 4,
    localparam int unsigned PtrW         = $clog2(FIFO_DEPTH),
    localparam int unsigned CntW         = PtrW + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] in_address,
    input  logic [ID_WIDTH-1:0]      in_id,
    input  logic                     in_valid,
    output logic                     out_stall,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    output logic [ID_WIDTH-1:0]      out_id,
    output logic                     out_valid,
    input  logic                     in_ready,
    output logic [CntW-1:0]          occupancy,
    output logic [ID_WIDTH-1:0]      expected_id,
    output logic                     order_error
);

    // Entry storage; deliberately not reset, contents are only meaningful below count_q.
    logic [ADDRESS_WIDTH-1:0] addr_mem_q [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]      id_mem_q   [FIFO_DEPTH];

    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [ID_WIDTH-1:0] expected_id_q, expected_id_d;
    logic                order_error_q, order_error_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Status decoded purely from registers so stall has no path from in_valid/in_ready.
    always_comb begin
        full  = (count_q == CntW'(FIFO_DEPTH));
        empty = (count_q == '0);
        // A pop while full does not free a slot for a same-cycle push.
        push  = in_valid && !full;
        pop   = !empty && in_ready;
    end

    // Next-state for pointers, occupancy and the order checker.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        expected_id_d = expected_id_q;
        order_error_d = order_error_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Checker always resynchronises to the incoming ID so one gap flags only once.
        if (push) begin
            if (in_id != expected_id_q) begin
                order_error_d = 1'b1;
            end
            expected_id_d = in_id + ID_WIDTH'(1);
        end
    end

    // Control state register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            expected_id_q <= '0;
            order_error_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            expected_id_q <= expected_id_d;
            order_error_q <= order_error_d;
        end
    end

    // Entry write on push; gated by reset so nothing lands during the reset edge.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            addr_mem_q[wr_ptr_q] <= in_address;
            id_mem_q[wr_ptr_q]   <= in_id;
        end
    end

    // Output decode: head entry and registered status.
    always_comb begin
        out_address = addr_mem_q[rd_ptr_q];
        out_id      = id_mem_q[rd_ptr_q];
        out_valid   = !empty;
        out_stall   = full;
        occupancy   = count_q;
        expected_id = expected_id_q;
        order_error = order_error_q;
    end

endmodule

// File: tb/tb_pipeline_drain_buffer.sv
// Scoreboard bench for pipeline_drain_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module tb_pipeline_drain_buffer;

    localparam int AW    = `ADDRESS_WIDTH;
    localparam int IDW   = `ID_WIDTH;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [AW-1:0]  in_address = '0;
    logic [IDW-1:0] in_id = '0;
    logic           in_valid = 1'b0;
    logic           in_ready = 1'b0;
    logic           out_stall;
    logic [AW-1:0]  out_address;
    logic [IDW-1:0] out_id;
    logic           out_valid;
    logic [CW-1:0]  occupancy;
    logic [IDW-1:0] expected_id;
    logic           order_error;

    pipeline_drain_buffer #(
        .ADDRESS_WIDTH(AW),
        .ID_WIDTH     (IDW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .in_address (in_address),
        .in_id      (in_id),
        .in_valid   (in_valid),
        .out_stall  (out_stall),
        .out_address(out_address),
        .out_id     (out_id),
        .out_valid  (out_valid),
        .in_ready   (in_ready),
        .occupancy  (occupancy),
        .expected_id(expected_id),
        .order_error(order_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the consumer must see, plus abstract counters.
    logic [AW+IDW-1:0] exp_q[$];
    int                m_count  = 0;
    logic [IDW-1:0]    m_exp_id = '0;
    bit                m_err    = 1'b0;
    bit                last_acc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Apply the spec rules to the inputs that were present at this edge.
    task automatic model_edge();
        bit acc;
        bit pp;
        if (rst) begin
            exp_q.delete();
            m_count  = 0;
            m_exp_id = '0;
            m_err    = 1'b0;
            last_acc = 1'b0;
        end else begin
            acc = in_valid && (m_count < DEPTH);
            pp  = in_ready && (m_count > 0);
            if (acc) begin
                exp_q.push_back({in_address, in_id});
                if (in_id != m_exp_id) m_err = 1'b1;
                m_exp_id = in_id + 1'b1;
            end
            m_count  = m_count + int'(acc) - int'(pp);
            last_acc = acc;
        end
    endtask

    task automatic check_state();
        chk("occupancy", 32'(occupancy), 32'(m_count));
        chk("out_valid", 32'(out_valid), 32'(m_count != 0));
        chk("out_stall", 32'(out_stall), 32'(m_count == DEPTH));
        chk("expected_id", 32'(expected_id), 32'(m_exp_id));
        chk("order_error", 32'(order_error), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_state();
    endtask

    task automatic drive(input bit v, input int id, input int a, input bit rdy);
        in_valid   = v;
        in_id      = IDW'(id);
        in_address = AW'(a);
        in_ready   = rdy;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_count > 0; i++) drive(0, 0, 0, 1);
        chk("drain_done", 32'(m_count), 32'd0);
    endtask

    // Monitor: every handshake the DUT presents must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && in_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", {31'd0, out_valid}, 32'd0);
            end else begin
                logic [AW+IDW-1:0] e;
                e = exp_q.pop_front();
                chk("head_id", 32'(out_id), 32'(e[IDW-1:0]));
                chk("head_addr", 32'(out_address), 32'(e[AW+IDW-1:IDW]));
            end
        end
    end

    initial begin
        bit             cur_v;
        int             cur_id;
        int             cur_a;
        int             next_id;

        rst = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        rst = 1'b0;

        // Single request after reset.
        drive(1, 0, 'h12, 1);
        chk("single_occ", 32'(occupancy), 32'd1);
        drive(0, 0, 0, 1);
        chk("single_occ_after", 32'(occupancy), 32'd0);
        chk("single_expid", 32'(expected_id), 32'd1);
        drive(0, 0, 0, 1);

        // Fill with consumer blocked; pipeline holds ID 4 while stalled.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, i, 'h100 + i, 0);
        chk("fill_stall", 32'(out_stall), 32'd1);
        drive(1, 4, 'h104, 0);
        drive(1, 4, 'h104, 0);
        chk("fill_hold_occ", 32'(occupancy), 32'd4);
        drive(1, 4, 'h104, 1);
        chk("fill_stall_drop", 32'(out_stall), 32'd0);
        drive(1, 4, 'h104, 0);
        chk("fill_id4_once", 32'(occupancy), 32'd4);
        drain();

        // Streaming push+pop.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, i, 'h200 + i, 1);
            chk("stream_occ", 32'(occupancy), 32'd1);
        end
        drain();

        // Order error with a gap, then sticky.
        do_reset();
        drive(1, 0, 'h10, 1);
        drive(1, 1, 'h11, 1);
        chk("order_ok_before_gap", 32'(order_error), 32'd0);
        drive(1, 3, 'h13, 1);
        chk("order_err_set", 32'(order_error), 32'd1);
        drive(1, 4, 'h14, 1);
        chk("order_err_sticky", 32'(order_error), 32'd1);
        chk("order_expid5", 32'(expected_id), 32'd5);
        drain();

        // ID wrap does not flag.
        do_reset();
        for (int i = 0; i <= (1 << IDW); i++) drive(1, i, i, 1);
        chk("wrap_no_err", 32'(order_error), 32'd0);
        drain();

        // Reset while full.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, i + 2, i, 0);
        chk("rf_stall", 32'(out_stall), 32'd1);
        rst = 1'b1;
        drive(1, 7, 'h77, 1);
        rst = 1'b0;
        chk("rf_occ", 32'(occupancy), 32'd0);
        chk("rf_valid", 32'(out_valid), 32'd0);
        chk("rf_err", 32'(order_error), 32'd0);
        drive(1, 0, 'h55, 1);
        chk("rf_push0_err", 32'(order_error), 32'd0);
        drain();

        // Randomized traffic; a request not accepted is held, as the pipeline would.
        do_reset();
        cur_v   = 0;
        cur_id  = 0;
        cur_a   = 0;
        next_id = 0;
        for (int c = 0; c < 600; c++) begin
            if (!(cur_v && !last_acc)) begin
                cur_v = ($urandom_range(0, 9) < 7);
                if (cur_v) begin
                    if ($urandom_range(0, 19) == 0) next_id = next_id + $urandom_range(1, 3);
                    cur_id  = next_id;
                    next_id = next_id + 1;
                    cur_a   = int'($urandom_range(0, (1 << AW) - 1));
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                drive(cur_v, cur_id, cur_a, $urandom_range(0, 1));
                rst     = 1'b0;
                cur_v   = 0;
                next_id = 0;
            end else begin
                drive(cur_v, cur_id, cur_a, ($urandom_range(0, 9) < 6));
            end
        end
        drain();
        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
